// File: rtl/cond_issue_controller_if.sv
// Valid/ready instruction channel shared by the fetch-side and execute-side
// links of the conditional issue controller.
interface cond_issue_controller_if #(
    parameter int INSTR_W = 32
);
    logic               valid;
    logic               ready;
    logic [INSTR_W-1:0] instr;

    modport master (output valid, output instr, input ready);
    modport slave  (input valid, input instr, output ready);
endinterface

// File: rtl/cond_issue_controller.sv
// Single-slot issue controller: holds one fetched ARM instruction, stalls on
// pending NZCV writes, then issues, skips (counted) or traps it by cond[31:28].
module cond_issue_controller #(
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    cond_issue_controller_if.slave  fetch,
    cond_issue_controller_if.master issue,
    input  logic [3:0]              flags_nzcv,
    input  logic                    flags_busy,
    input  logic                    flush,
    output logic                    skip_pulse,
    output logic [CNT_W-1:0]        skip_count,
    output logic                    undef_pulse,
    input  logic                    trap_ack
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HELD  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_TRAP  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [INSTR_W-1:0] held_r;
    logic [INSTR_W-1:0] issue_instr_r;
    logic               issue_valid_r;
    logic               skip_pulse_r;
    logic               undef_pulse_r;
    logic [CNT_W-1:0]   skip_count_r;

    logic [3:0]         cond_s;
    logic               accept_s;
    logic               evaluate_s;
    logic               pass_s;
    logic               skip_s;
    logic               trap_s;

    // ARM condition-code evaluation against {N,Z,C,V}; 0xF never passes.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n;
        logic z;
        logic c;
        logic v;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = ~z;
            4'h2:    cond_pass = c;
            4'h3:    cond_pass = ~c;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = ~n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = ~v;
            4'h8:    cond_pass = c & ~z;
            4'h9:    cond_pass = ~c | z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = ~z & (n == v);
            4'hD:    cond_pass = z | (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    assign cond_s      = held_r[31:28];
    assign fetch.ready = (state_r == ST_EMPTY) & ~flush & ~reset;
    assign issue.valid = issue_valid_r;
    assign issue.instr = issue_instr_r;
    assign skip_pulse  = skip_pulse_r;
    assign skip_count  = skip_count_r;
    assign undef_pulse = undef_pulse_r;

    // Decode this cycle's events; flush masks every outcome of the held slot.
    always_comb begin
        accept_s   = (state_r == ST_EMPTY) & fetch.valid & ~flush;
        evaluate_s = (state_r == ST_HELD) & ~flags_busy & ~flush;
        trap_s     = evaluate_s & (cond_s == 4'hF);
        pass_s     = evaluate_s & (cond_s != 4'hF) & cond_pass(cond_s, flags_nzcv);
        skip_s     = evaluate_s & (cond_s != 4'hF) & ~cond_pass(cond_s, flags_nzcv);
    end

    // Next-state selection with flush taking priority over every state.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (fetch.valid) state_nxt_s = ST_HELD;
                    else             state_nxt_s = ST_EMPTY;
                end
                ST_HELD: begin
                    if (flags_busy)    state_nxt_s = ST_HELD;
                    else if (trap_s)   state_nxt_s = ST_TRAP;
                    else if (pass_s)   state_nxt_s = ST_ISSUE;
                    else               state_nxt_s = ST_EMPTY;
                end
                ST_ISSUE: begin
                    if (issue.ready) state_nxt_s = ST_EMPTY;
                    else             state_nxt_s = ST_ISSUE;
                end
                ST_TRAP: begin
                    if (trap_ack) state_nxt_s = ST_EMPTY;
                    else          state_nxt_s = ST_TRAP;
                end
                default: state_nxt_s = ST_EMPTY;
            endcase
        end
    end

    // State, holding register and issue outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_EMPTY;
            held_r        <= {INSTR_W{1'b0}};
            issue_instr_r <= {INSTR_W{1'b0}};
            issue_valid_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            issue_valid_r <= (state_nxt_s == ST_ISSUE);
            if (accept_s) begin
                held_r <= fetch.instr;
            end
            if (pass_s) begin
                issue_instr_r <= held_r;
            end
        end
    end

    // Outcome pulses and the saturating skip counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_pulse_r  <= 1'b0;
            undef_pulse_r <= 1'b0;
            skip_count_r  <= {CNT_W{1'b0}};
        end else begin
            skip_pulse_r  <= skip_s;
            undef_pulse_r <= trap_s;
            if (skip_s && (skip_count_r != CNT_MAX)) begin
                skip_count_r <= skip_count_r + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_cond_issue_controller.sv
// Directed bench for cond_issue_controller: a table of condition-code vectors
// plus hand-written stall, flush, trap and reset sequences.
module tb_cond_issue_controller;

    localparam int TB_CNT_W = 2;
    localparam int CNT_SAT  = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [3:0]          flags_nzcv = 4'b0000;
    logic                flags_busy = 1'b0;
    logic                flush = 1'b0;
    logic                trap_ack = 1'b0;
    logic                skip_pulse;
    logic [TB_CNT_W-1:0] skip_count;
    logic                undef_pulse;

    cond_issue_controller_if #(.INSTR_W(32)) fetch_bus ();
    cond_issue_controller_if #(.INSTR_W(32)) issue_bus ();

    cond_issue_controller #(.INSTR_W(32), .CNT_W(TB_CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch       (fetch_bus),
        .issue       (issue_bus),
        .flags_nzcv  (flags_nzcv),
        .flags_busy  (flags_busy),
        .flush       (flush),
        .skip_pulse  (skip_pulse),
        .skip_count  (skip_count),
        .undef_pulse (undef_pulse),
        .trap_ack    (trap_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [3:0]  nzcv;
        logic        exp_issue;
        logic        exp_skip;
        logic        exp_undef;
    } vec_t;

    vec_t vecs [20];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One bench cycle: drive at the falling edge, settle, then caller checks.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [3:0] nzcv,
                       input logic busy, input logic fl, input logic rdy, input logic ack);
        @(negedge clk);
        fetch_bus.valid = v;
        fetch_bus.instr = ins;
        flags_nzcv      = nzcv;
        flags_busy      = busy;
        flush           = fl;
        issue_bus.ready = rdy;
        trap_ack        = ack;
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic rdy, input logic iv,
                            input logic sk, input logic ud);
        check({tag, ".in_ready"},    {31'd0, fetch_bus.ready}, {31'd0, rdy});
        check({tag, ".issue_valid"}, {31'd0, issue_bus.valid}, {31'd0, iv});
        check({tag, ".skip_pulse"},  {31'd0, skip_pulse},      {31'd0, sk});
        check({tag, ".undef_pulse"}, {31'd0, undef_pulse},     {31'd0, ud});
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        cyc(1'b1, v.instr, v.nzcv, 1'b0, 1'b0, 1'b1, 1'b0);
        check({tag, ".accept_ready"}, {31'd0, fetch_bus.ready}, 32'd1);
        cyc(1'b0, 32'h0, v.nzcv, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_outs({tag, ".held"}, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, v.nzcv, 1'b0, 1'b0, 1'b1, v.exp_undef);
        if (v.exp_skip && exp_cnt < CNT_SAT) exp_cnt++;
        chk_outs({tag, ".outcome"}, v.exp_skip, v.exp_issue, v.exp_skip, v.exp_undef);
        check({tag, ".skip_count"}, {30'd0, skip_count}, exp_cnt);
        if (v.exp_issue) check({tag, ".issue_instr"}, issue_bus.instr, v.instr);
        cyc(1'b0, 32'h0, v.nzcv, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_outs({tag, ".after"}, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        fetch_bus.valid = 1'b0;
        fetch_bus.instr = 32'h0;
        issue_bus.ready = 1'b0;

        vecs[0]  = '{32'hE3A00001, 4'b0000, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{32'h1A000000, 4'b0100, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'h0A000011, 4'b0100, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{32'h0A000012, 4'b0000, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{32'h2A000020, 4'b0010, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{32'h3A000030, 4'b0010, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{32'h4A000040, 4'b1000, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{32'h5A000050, 4'b1000, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{32'h6A000060, 4'b0001, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{32'h7A000070, 4'b0000, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{32'h8A000080, 4'b0010, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{32'h8A000081, 4'b0110, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{32'h9A000090, 4'b0110, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{32'hAA0000A0, 4'b1001, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{32'hBA0000B0, 4'b1000, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{32'hBA0000B1, 4'b0000, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{32'hCA0000C0, 4'b1001, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{32'hCA0000C1, 4'b1101, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{32'hDA0000D0, 4'b0100, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{32'hF0000000, 4'b0000, 1'b0, 1'b0, 1'b1};

        // Reset state.
        #12;
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.issue_instr", issue_bus.instr, 32'h0);
        check("reset.skip_count", {30'd0, skip_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset.release_ready", {31'd0, fetch_bus.ready}, 32'd1);

        // Stall on flags_busy; flags change mid-stall, evaluation uses the busy=0 cycle.
        cyc(1'b1, 32'h0A000000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        check("stall.accept", {31'd0, fetch_bus.ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 32'h0, (i >= 2) ? 4'b0100 : 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
            chk_outs($sformatf("stall.busy%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b0, 32'h0, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_outs("stall.eval", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_outs("stall.issue", 1'b0, 1'b1, 1'b0, 1'b0);
        check("stall.issue_instr", issue_bus.instr, 32'h0A000000);
        cyc(1'b0, 32'h0, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_outs("stall.done", 1'b1, 1'b0, 1'b0, 1'b0);

        // Fetch offered during flush is refused.
        cyc(1'b1, 32'hE0000001, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        check("flush_empty.ready", {31'd0, fetch_bus.ready}, 32'd0);
        cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_outs("flush_empty.after", 1'b1, 1'b0, 1'b0, 1'b0);

        // Flush while holding a failing instruction: no skip pulse, count unchanged.
        cyc(1'b1, 32'h1A000002, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 4'b0100, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_outs("flush_held.cycle", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_outs("flush_held.after", 1'b1, 1'b0, 1'b0, 1'b0);
        check("flush_held.skip_count", {30'd0, skip_count}, 32'd0);

        // Flush in ISSUE with execute stalled: valid stable until flush, then dropped.
        cyc(1'b1, 32'hE1A00000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
            chk_outs($sformatf("flush_issue.hold%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
            check($sformatf("flush_issue.instr%0d", i), issue_bus.instr, 32'hE1A00000);
        end
        cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_outs("flush_issue.cycle", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_outs("flush_issue.after", 1'b1, 1'b0, 1'b0, 1'b0);
        check("flush_issue.skip_count", {30'd0, skip_count}, 32'd0);

        // Flush coincident with the issue handshake.
        cyc(1'b1, 32'hE1A00002, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_outs("flush_hs.cycle", 1'b0, 1'b1, 1'b0, 1'b0);
        check("flush_hs.instr", issue_bus.instr, 32'hE1A00002);
        cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_outs("flush_hs.after", 1'b1, 1'b0, 1'b0, 1'b0);

        // Condition table; skips drive the 2-bit counter into saturation.
        for (int i = 0; i < 20; i++) run_vec(i, vecs[i]);
        check("sat.skip_count", {30'd0, skip_count}, CNT_SAT);

        // Trap held across cycles with fetch and issue_ready asserted.
        cyc(1'b1, 32'hF0000001, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 32'hE0000003, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 32'hE0000003, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_outs("trap.enter", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'hE0000003, 4'b0000, 1'b0, 1'b0, 1'b1, (i == 2) ? 1'b1 : 1'b0);
            chk_outs($sformatf("trap.wait%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_outs("trap.exit", 1'b1, 1'b0, 1'b0, 1'b0);
        check("trap.skip_count", {30'd0, skip_count}, CNT_SAT);

        // Asynchronous reset in ISSUE clears everything immediately.
        cyc(1'b1, 32'hE2000005, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_outs("rst_mid.pre", 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        chk_outs("rst_mid.now", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid.issue_instr", issue_bus.instr, 32'h0);
        check("rst_mid.skip_count", {30'd0, skip_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_outs("rst_mid.release", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
